fifo_writer: RTL and testbench

FIFO_WRITER -- requirements
Module: fifo_writer

---
 rtl/fifo_writer.sv | 179 +++++++++++++++++
 tb/tb_fifo_writer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_writer.sv
// fifo_writer: accepts an AXI-Stream-like packet stream and writes it into a FIFO.
// The drop-or-pass choice is made once, on the first beat of each packet, from a
// synchronised copy of fifo_full. Packets longer than MAX_PKT_BEATS are truncated.
// Optional feature: define FIFO_WRITER_SEQ_EN to prefix every written packet with a
// header word {zeros, seq[31:0]}.
module fifo_writer #(
    parameter int unsigned WIDTH         = 512,
    parameter int unsigned MAX_PKT_BEATS = 16
) (
    input  logic             wr_clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    output logic             s_tready,
    output logic             fifo_wr_en,
    output logic [WIDTH-1:0] fifo_data,
    input  logic             fifo_full,
    output logic [31:0]      pkt_cnt,
    output logic [31:0]      drop_cnt,
    output logic [31:0]      trunc_cnt
);

    localparam int unsigned BeatW = $clog2(MAX_PKT_BEATS + 1);
    localparam logic [BeatW-1:0] MaxBeats = BeatW'(MAX_PKT_BEATS);

`ifdef FIFO_WRITER_SEQ_EN
    typedef enum logic [1:0] {StIdle, StHdr, StPass, StDrop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StPass, StDrop} state_e;
`endif

    state_e             r_state;
    state_e             w_state_d;
    logic               r_full_meta;
    logic               r_full_s;
    logic               r_wr_en;
    logic               w_wr_en_d;
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   w_data_d;
    logic [BeatW-1:0]   r_beat_cnt;
    logic [BeatW-1:0]   w_beat_d;
    logic [31:0]        r_pkt_cnt;
    logic [31:0]        r_drop_cnt;
    logic [31:0]        r_trunc_cnt;
    logic               w_pkt_inc;
    logic               w_drop_inc;
    logic               w_trunc_inc;
    logic               w_ready;
    logic               w_accept;
`ifdef FIFO_WRITER_SEQ_EN
    logic [31:0]        r_seq;
    logic               w_seq_inc;
`endif

    // Ready is a function of state only; forced low while reset is held.
`ifdef FIFO_WRITER_SEQ_EN
    assign w_ready = (r_state == StPass) || (r_state == StDrop);
`else
    assign w_ready = 1'b1;
`endif
    assign s_tready   = w_ready & ~reset;
    assign w_accept   = s_tvalid & s_tready;

    assign fifo_wr_en = r_wr_en;
    assign fifo_data  = r_data;
    assign pkt_cnt    = r_pkt_cnt;
    assign drop_cnt   = r_drop_cnt;
    assign trunc_cnt  = r_trunc_cnt;

    // Two-flop synchroniser for the asynchronous FIFO full flag.
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            r_full_meta <= 1'b0;
            r_full_s    <= 1'b0;
        end else begin
            r_full_meta <= fifo_full;
            r_full_s    <= r_full_meta;
        end
    end

    // Next-state, write strobe/data and counter increment decode.
    always_comb begin
        w_state_d   = r_state;
        w_wr_en_d   = 1'b0;
        w_data_d    = r_data;
        w_beat_d    = r_beat_cnt;
        w_pkt_inc   = 1'b0;
        w_drop_inc  = 1'b0;
        w_trunc_inc = 1'b0;
`ifdef FIFO_WRITER_SEQ_EN
        w_seq_inc   = 1'b0;
`endif
        unique case (r_state)
            StIdle: begin
                w_beat_d = '0;
`ifdef FIFO_WRITER_SEQ_EN
                // Stall the first beat while the header goes out.
                if (s_tvalid) begin
                    w_state_d = r_full_s ? StDrop : StHdr;
                end
`else
                if (w_accept) begin
                    if (r_full_s) begin
                        if (s_tlast) w_drop_inc = 1'b1;
                        else         w_state_d  = StDrop;
                    end else begin
                        w_wr_en_d = 1'b1;
                        w_data_d  = s_tdata;
                        w_beat_d  = BeatW'(1);
                        if (s_tlast) w_pkt_inc = 1'b1;
                        else         w_state_d = StPass;
                    end
                end
`endif
            end
`ifdef FIFO_WRITER_SEQ_EN
            StHdr: begin
                w_wr_en_d = 1'b1;
                w_data_d  = WIDTH'(r_seq);
                w_seq_inc = 1'b1;
                w_state_d = StPass;
            end
`endif
            StPass: begin
                if (w_accept) begin
                    // Beat count saturates at MaxBeats, so reaching it marks truncation.
                    if (r_beat_cnt < MaxBeats) begin
                        w_wr_en_d = 1'b1;
                        w_data_d  = s_tdata;
                        w_beat_d  = r_beat_cnt + BeatW'(1);
                    end
                    if (s_tlast) begin
                        w_pkt_inc   = 1'b1;
                        w_trunc_inc = (r_beat_cnt >= MaxBeats);
                        w_state_d   = StIdle;
                    end
                end
            end
            StDrop: begin
                if (w_accept && s_tlast) begin
                    w_drop_inc = 1'b1;
                    w_state_d  = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // State, output registers and packet counters.
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_wr_en     <= 1'b0;
            r_data      <= '0;
            r_beat_cnt  <= '0;
            r_pkt_cnt   <= '0;
            r_drop_cnt  <= '0;
            r_trunc_cnt <= '0;
        end else begin
            r_state    <= w_state_d;
            r_wr_en    <= w_wr_en_d;
            r_data     <= w_data_d;
            r_beat_cnt <= w_beat_d;
            if (w_pkt_inc)   r_pkt_cnt   <= r_pkt_cnt + 32'd1;
            if (w_drop_inc)  r_drop_cnt  <= r_drop_cnt + 32'd1;
            if (w_trunc_inc) r_trunc_cnt <= r_trunc_cnt + 32'd1;
        end
    end

`ifdef FIFO_WRITER_SEQ_EN
    // Header sequence number, one step per header written.
    always_ff @(posedge wr_clk) begin
        if (reset)          r_seq <= '0;
        else if (w_seq_inc) r_seq <= r_seq + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fifo_writer.sv
// Bench for fifo_writer: scoreboard of expected FIFO writes checked by a monitor,
// plus per-scenario counter and handshake checks.
module tb_fifo_writer;

    localparam int unsigned WIDTH         = 512;
    localparam int unsigned MAX_PKT_BEATS = 16;

    logic             wr_clk = 1'b0;
    logic             reset  = 1'b1;
    logic [WIDTH-1:0] s_tdata = '0;
    logic             s_tvalid = 1'b0;
    logic             s_tlast  = 1'b0;
    logic             s_tready;
    logic             fifo_wr_en;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_full = 1'b0;
    logic [31:0]      pkt_cnt;
    logic [31:0]      drop_cnt;
    logic [31:0]      trunc_cnt;

    fifo_writer #(
        .WIDTH         (WIDTH),
        .MAX_PKT_BEATS (MAX_PKT_BEATS)
    ) dut (
        .wr_clk     (wr_clk),
        .reset      (reset),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .fifo_wr_en (fifo_wr_en),
        .fifo_data  (fifo_data),
        .fifo_full  (fifo_full),
        .pkt_cnt    (pkt_cnt),
        .drop_cnt   (drop_cnt),
        .trunc_cnt  (trunc_cnt)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        int unsigned      cyc;
        bit               chk_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    logic [31:0] m_pkt    = '0;
    logic [31:0] m_drop   = '0;
    logic [31:0] m_trunc  = '0;

    always @(posedge wr_clk) cyc <= cyc + 1;

    // Every observed write must match the head of the scoreboard.
    always @(negedge wr_clk) begin
        exp_t e;
        if (!reset && fifo_wr_en === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got data %h at cycle %0d, required no write",
                         fifo_data, cyc);
            end else begin
                e = exp_q.pop_front();
                if (fifo_data !== e.data || (e.chk_cyc && cyc != e.cyc)) begin
                    n_fail++;
                    $display("FAIL write_data: got %h at cycle %0d, required %h at cycle %0d",
                             fifo_data, cyc, e.data, e.cyc);
                end
            end
        end
    end

    function automatic logic [WIDTH-1:0] rand_word();
        logic [WIDTH-1:0] v;
        for (int i = 0; i < WIDTH / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge wr_clk);
        #1;
    endtask

    // Present one beat; called just after a rising edge, returns just after acceptance.
    task automatic send_beat(input logic [WIDTH-1:0] d, input bit last, input bit wr,
                             output int waited);
        s_tdata  = d;
        s_tlast  = last;
        s_tvalid = 1'b1;
        waited   = 0;
        @(negedge wr_clk);
        while (s_tready !== 1'b1 && waited < 50) begin
            waited++;
            @(negedge wr_clk);
        end
        if (s_tready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: s_tready=%b after %0d cycles, required 1",
                     s_tready, waited);
        end else if (wr) begin
            exp_q.push_back('{d, cyc + 1, 1'b1});
        end
        @(posedge wr_clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_pkt(input int n, input int n_wr, output int max_wait);
        int w;
        max_wait = 0;
        for (int i = 0; i < n; i++) begin
            send_beat(rand_word(), (i == n - 1), (i < n_wr), w);
            if (w > max_wait) max_wait = w;
        end
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        fifo_full = 1'b0;
        wait_cycles(3);
        @(negedge wr_clk);
        n_checks++;
        if (s_tready !== 1'b0 || fifo_wr_en !== 1'b0 || fifo_data !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b wr_en=%b data=%h, required 0 0 0",
                     s_tready, fifo_wr_en, fifo_data);
        end
        n_checks++;
        if (pkt_cnt !== 32'd0 || drop_cnt !== 32'd0 || trunc_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got %0d %0d %0d, required 0 0 0",
                     pkt_cnt, drop_cnt, trunc_cnt);
        end
        @(posedge wr_clk);
        #1;
        reset = 1'b0;
        wait_cycles(3);
    endtask

    task automatic check_counters(input string name);
        wait_cycles(3);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending: got %0d writes outstanding, required 0",
                     name, exp_q.size());
            exp_q.delete();
        end
        n_checks++;
        if (pkt_cnt !== m_pkt || drop_cnt !== m_drop || trunc_cnt !== m_trunc) begin
            n_fail++;
            $display("FAIL %s_counters: got pkt=%0d drop=%0d trunc=%0d, required %0d %0d %0d",
                     name, pkt_cnt, drop_cnt, trunc_cnt, m_pkt, m_drop, m_trunc);
        end
    endtask

    task automatic test_pass;
        int w;
        send_pkt(3, 3, w);
        m_pkt++;
        check_counters("pass");
    endtask

    task automatic test_drop;
        int w;
        fifo_full = 1'b1;
        wait_cycles(4);
        send_pkt(2, 0, w);
        n_checks++;
        if (w != 0) begin
            n_fail++;
            $display("FAIL drop_ready: got %0d stall cycles, required 0", w);
        end
        m_drop++;
        check_counters("drop");
        fifo_full = 1'b0;
        wait_cycles(4);
    endtask

    task automatic test_full_midpacket;
        int w;
        send_beat(rand_word(), 1'b0, 1'b1, w);
        fifo_full = 1'b1;
        for (int i = 1; i < 4; i++) send_beat(rand_word(), (i == 3), 1'b1, w);
        m_pkt++;
        check_counters("full_mid");
        fifo_full = 1'b0;
        wait_cycles(4);
    endtask

    task automatic test_trunc;
        int w;
        send_pkt(20, MAX_PKT_BEATS, w);
        m_pkt++;
        m_trunc++;
        check_counters("trunc");
    endtask

    task automatic test_back_to_back;
        int w;
        for (int i = 0; i < 4; i++) send_pkt(1, 1, w);
        // Exactly MAX_PKT_BEATS beats: all written, not truncated.
        send_pkt(MAX_PKT_BEATS, MAX_PKT_BEATS, w);
        m_pkt += 5;
        check_counters("b2b");
    endtask

    task automatic test_reset_midpacket;
        int w;
        send_beat(rand_word(), 1'b0, 1'b1, w);
        @(negedge wr_clk);
        #1;
        reset    = 1'b1;
        s_tdata  = rand_word();
        s_tvalid = 1'b1;
        repeat (2) @(posedge wr_clk);
        @(negedge wr_clk);
        n_checks++;
        if (fifo_wr_en !== 1'b0 || s_tready !== 1'b0 || pkt_cnt !== 32'd0 ||
            drop_cnt !== 32'd0 || trunc_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL midreset_state: got wr_en=%b ready=%b cnt=%0d/%0d/%0d, required all 0",
                     fifo_wr_en, s_tready, pkt_cnt, drop_cnt, trunc_cnt);
        end
        @(posedge wr_clk);
        #1;
        reset    = 1'b0;
        s_tvalid = 1'b0;
        m_pkt    = '0;
        m_drop   = '0;
        m_trunc  = '0;
        send_pkt(3, 3, w);
        m_pkt++;
        check_counters("midreset");
    endtask

`ifdef FIFO_WRITER_SEQ_EN
    task automatic test_seq;
        int w;
        for (int p = 0; p < 2; p++) begin
            exp_q.push_back('{WIDTH'(p), 0, 1'b0});
            send_beat(rand_word(), 1'b1, 1'b1, w);
            n_checks++;
            if (w == 0) begin
                n_fail++;
                $display("FAIL seq_ready: got %0d stall cycles before packet %0d, required >0",
                         w, p);
            end
            m_pkt++;
        end
        check_counters("seq");
    endtask
`endif

    initial begin
        test_reset;
`ifdef FIFO_WRITER_SEQ_EN
        test_seq;
`else
        test_pass;
        test_drop;
        test_full_midpacket;
        test_trunc;
        test_back_to_back;
        test_reset_midpacket;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
